// File: rtl/key_switch_capture.sv
// key_switch_capture
// Avalon-MM slave that presents debounced pushbuttons (active-low on the pins)
// and slide switches to the CPU. Adds a per-key press capture register, an
// interrupt mask and a wrapping 16-bit press counter.
//
// Ports:
//   clk_clk            : system clock, all logic on the rising edge
//   reset_reset        : synchronous, active-high reset
//   avs_address[1:0]   : word address (0 DATA, 1 IRQ_MASK, 2 EDGE_CAPTURE, 3 PRESS_COUNT)
//   avs_read/avs_write : bus strobes; a write wins when both are asserted
//   avs_writedata[31:0]: write data
//   avs_readdata[31:0] : read data, fixed latency 1, holds when not valid
//   avs_readdatavalid  : one-cycle read data strobe
//   irq                : level interrupt, registered OR of (EDGE_CAPTURE & IRQ_MASK)
//   keys_export        : raw keys, 0 = pressed, asynchronous
//   sw_export          : raw switches, asynchronous
//
// Build option:
//   KEYCAP_SW_DEBOUNCE_EN : defined -> switches get the same debouncer as keys;
//                           undefined -> switches are only 2-flop synchronized.

// Synchronizer plus per-bit debouncer. o_accept pulses in the cycle whose
// rising edge copies the synchronized value into the stable bit.
module key_switch_capture_debounce #(
  parameter int   W               = 1,
  parameter int   DEBOUNCE_CYCLES = 1,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_stable,
  output logic [W-1:0] o_accept
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The edge that would take the counter to DEBOUNCE_CYCLES is the accept edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     r_sync1;
  logic [W-1:0]     r_sync2;
  logic [W-1:0]     r_stable;
  logic [CNT_W-1:0] r_cnt [W];
  logic [W-1:0]     w_accept;

  // Two-flop synchronizer for the asynchronous pins
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= {W{RST_VAL}};
      r_sync2 <= {W{RST_VAL}};
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept decode: mismatch that has persisted long enough
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < W; i++) begin
      if ((r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST)) begin
        w_accept[i] = 1'b1;
      end else begin
        w_accept[i] = 1'b0;
      end
    end
  end

  // Stable bits and their mismatch counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stable <= {W{RST_VAL}};
      for (int i = 0; i < W; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign o_stable = r_stable;
  assign o_accept = w_accept;
endmodule

module key_switch_capture #(
  parameter int KEY_W           = 4,
  parameter int SW_W            = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic              irq,
  input  logic [KEY_W-1:0]  keys_export,
  input  logic [SW_W-1:0]   sw_export
);
  logic [KEY_W-1:0] w_key_stable;
  logic [KEY_W-1:0] w_key_accept;
  logic [KEY_W-1:0] w_key_press;
  logic [SW_W-1:0]  w_sw_state;
  logic             w_wr_mask;
  logic             w_wr_edge;
  logic             w_wr_cnt;
  logic [31:0]      w_rd_data;
  logic             w_unused_wdata;

  logic [KEY_W-1:0] r_irq_mask;
  logic [KEY_W-1:0] r_edge_cap;
  logic [15:0]      r_press_cnt;
  logic             r_irq;
  logic [31:0]      r_readdata;
  logic             r_readdatavalid;

  function automatic logic [15:0] popcount(input logic [KEY_W-1:0] v);
    logic [15:0] n;
    n = 16'd0;
    for (int i = 0; i < KEY_W; i++) begin
      n = n + {15'd0, v[i]};
    end
    return n;
  endfunction

  key_switch_capture_debounce #(
    .W(KEY_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)
  ) u_key_db (
    .i_clk(clk_clk), .i_rst(reset_reset), .i_raw(keys_export),
    .o_stable(w_key_stable), .o_accept(w_key_accept)
  );

  // An accepted change on a key whose stable bit is 1 (released) is a press.
  assign w_key_press = w_key_accept & w_key_stable;

`ifdef KEYCAP_SW_DEBOUNCE_EN
  logic [SW_W-1:0] w_unused_sw_accept;

  key_switch_capture_debounce #(
    .W(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)
  ) u_sw_db (
    .i_clk(clk_clk), .i_rst(reset_reset), .i_raw(sw_export),
    .o_stable(w_sw_state), .o_accept(w_unused_sw_accept)
  );
`else
  logic [SW_W-1:0] r_sw_sync1;
  logic [SW_W-1:0] r_sw_sync2;

  // Switch synchronizer only; no debounce
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
    end else begin
      r_sw_sync1 <= sw_export;
      r_sw_sync2 <= r_sw_sync1;
    end
  end

  assign w_sw_state = r_sw_sync2;
`endif

  assign w_wr_mask      = avs_write && (avs_address == 2'd1);
  assign w_wr_edge      = avs_write && (avs_address == 2'd2);
  assign w_wr_cnt       = avs_write && (avs_address == 2'd3);
  assign w_unused_wdata = ^avs_writedata;

  // Read data multiplexer
  always_comb begin
    w_rd_data = 32'd0;
    case (avs_address)
      2'd0:    w_rd_data = 32'({w_sw_state, ~w_key_stable});
      2'd1:    w_rd_data = 32'(r_irq_mask);
      2'd2:    w_rd_data = 32'(r_edge_cap);
      2'd3:    w_rd_data = 32'(r_press_cnt);
      default: w_rd_data = 32'd0;
    endcase
  end

  // Mask, edge capture (set beats clear), press counter and interrupt
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_irq_mask  <= '0;
      r_edge_cap  <= '0;
      r_press_cnt <= 16'd0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr_mask) begin
        r_irq_mask <= avs_writedata[KEY_W-1:0];
      end
      if (w_wr_edge) begin
        r_edge_cap <= (r_edge_cap & ~avs_writedata[KEY_W-1:0]) | w_key_press;
      end else begin
        r_edge_cap <= r_edge_cap | w_key_press;
      end
      // A write restarts the count from this cycle's presses.
      if (w_wr_cnt) begin
        r_press_cnt <= popcount(w_key_press);
      end else begin
        r_press_cnt <= r_press_cnt + popcount(w_key_press);
      end
      r_irq <= |(r_edge_cap & r_irq_mask);
    end
  end

  // Read response: latency 1, data held between reads, suppressed by a write
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_readdata      <= 32'd0;
      r_readdatavalid <= 1'b0;
    end else if (avs_read && !avs_write) begin
      r_readdata      <= w_rd_data;
      r_readdatavalid <= 1'b1;
    end else begin
      r_readdatavalid <= 1'b0;
    end
  end

  assign avs_readdata      = r_readdata;
  assign avs_readdatavalid = r_readdatavalid;
  assign irq               = r_irq;
endmodule

// File: tb/tb_key_switch_capture.sv
module tb_key_switch_capture;
  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef KEYCAP_SW_DEBOUNCE_EN
  localparam int SW_LAT = 6;
`else
  localparam int SW_LAT = 2;
`endif

  // Main DUT: KEY_W=4, SW_W=10, DEBOUNCE_CYCLES=4
  logic        rst;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        irq;
  logic [3:0]  keys;
  logic [9:0]  sw;

  // Wrap DUT: 16 keys, DEBOUNCE_CYCLES=1, to reach 0xFFFF quickly
  logic [1:0]  a2;
  logic        rd2;
  logic        wr2;
  logic [31:0] wd2;
  logic [31:0] rdata2;
  logic        rdv2;
  logic        irq2;
  logic [15:0] k2;
  logic [0:0]  sw2;

  key_switch_capture #(.KEY_W(4), .SW_W(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk_clk(clk), .reset_reset(rst), .avs_address(avs_address),
    .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .irq(irq), .keys_export(keys), .sw_export(sw)
  );

  key_switch_capture #(.KEY_W(16), .SW_W(1), .DEBOUNCE_CYCLES(1)) dut_wrap (
    .clk_clk(clk), .reset_reset(rst), .avs_address(a2),
    .avs_read(rd2), .avs_readdata(rdata2), .avs_readdatavalid(rdv2),
    .avs_write(wr2), .avs_writedata(wd2), .irq(irq2), .keys_export(k2), .sw_export(sw2)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] sb_q [$];
  string       sb_name [$];

  typedef struct {
    logic [3:0]  keys;
    logic [9:0]  sw;
    logic [31:0] exp_data;
  } vec_t;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Scoreboard: every read pushes its expectation; each readdatavalid pops one.
  always @(negedge clk) begin
    logic [31:0] e;
    string nm;
    if (avs_readdatavalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("rdv_unexpected", {63'd0, avs_readdatavalid}, 64'd0);
      end else begin
        e  = sb_q.pop_front();
        nm = sb_name.pop_front();
        chk(nm, {32'd0, avs_readdata}, {32'd0, e});
      end
    end
  end

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
    avs_address = a;
    avs_read    = 1'b1;
    sb_q.push_back(exp);
    sb_name.push_back(nm);
    @(negedge clk);
    avs_read = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_write     = 1'b1;
    avs_writedata = d;
    @(negedge clk);
    avs_write     = 1'b0;
    avs_writedata = 32'd0;
  endtask

  task automatic read2(input logic [1:0] a, input logic [31:0] exp, input string nm);
    a2  = a;
    rd2 = 1'b1;
    @(negedge clk);
    rd2 = 1'b0;
    chk(nm, {31'd0, rdv2, rdata2}, {31'd0, 1'b1, exp});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t        tbl [6];
    logic [3:0]  prev;
    logic [3:0]  p;
    logic [15:0] model_cnt;

    tbl[0] = '{4'hF, 10'h000, 32'h0000_0000};
    tbl[1] = '{4'hE, 10'h2A5, 32'h0000_2A51};
    tbl[2] = '{4'hA, 10'h155, 32'h0000_1555};
    tbl[3] = '{4'h0, 10'h3FF, 32'h0000_3FFF};
    tbl[4] = '{4'hF, 10'h000, 32'h0000_0000};
    tbl[5] = '{4'h6, 10'h001, 32'h0000_0019};

    rst = 1'b1; avs_address = 2'd0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = 32'd0; keys = 4'hF; sw = 10'h000;
    a2 = 2'd0; rd2 = 1'b0; wr2 = 1'b0; wd2 = 32'd0; k2 = 16'hFFFF; sw2 = 1'b0;
    model_cnt = 16'd0;
    prev = 4'hF;

    repeat (3) @(negedge clk);
    chk("rst_rdv", {63'd0, avs_readdatavalid}, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    chk("rst_rdata", {32'd0, avs_readdata}, 64'd0);
    rst = 1'b0;

    bus_read(2'd0, 32'h0, "reset_data");
    bus_read(2'd1, 32'h0, "reset_mask");
    bus_read(2'd2, 32'h0, "reset_ec");
    bus_read(2'd3, 32'h0, "reset_cnt");

    // Mask width, readdata hold, write-wins-over-read, DATA read-only
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, 32'h0000_000F, "mask_upper_zero");
    bus_write(2'd1, 32'h0);
    chk("rdata_hold", {32'd0, avs_readdata}, 64'h0000_000F);
    avs_address = 2'd1; avs_read = 1'b1; avs_write = 1'b1; avs_writedata = 32'h3;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'd0;
    @(negedge clk);
    bus_read(2'd1, 32'h3, "rw_write_done");
    bus_write(2'd1, 32'h0);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, 32'h0, "data_read_only");

    // Table of settled input patterns
    for (int i = 0; i < 6; i++) begin
      keys = tbl[i].keys;
      sw   = tbl[i].sw;
      repeat (8) @(negedge clk);
      p = prev & ~tbl[i].keys;
      model_cnt = model_cnt + 16'($countones(p));
      bus_read(2'd0, tbl[i].exp_data, "tbl_data");
      bus_read(2'd2, {28'd0, p}, "tbl_ec");
      bus_read(2'd3, {16'd0, model_cnt}, "tbl_cnt");
      bus_write(2'd2, 32'hF);
      prev = tbl[i].keys;
    end

    // Press latency and irq timing
    keys = 4'hF; sw = 10'h000;
    repeat (8) @(negedge clk);
    bus_write(2'd2, 32'hF);
    bus_write(2'd1, 32'h1);
    keys = 4'hE;
    repeat (5) @(negedge clk);
    chk("irq_pre_press", {63'd0, irq}, 64'd0);
    bus_read(2'd0, 32'h0, "press_edge5");
    chk("irq_at_ec_set", {63'd0, irq}, 64'd0);
    bus_read(2'd0, 32'h1, "press_edge6");
    chk("irq_rise", {63'd0, irq}, 64'd1);
    model_cnt = model_cnt + 16'd1;
    bus_read(2'd2, 32'h1, "press_ec");
    bus_read(2'd3, {16'd0, model_cnt}, "press_cnt");

    // Glitch of 3 cycles on key 2
    keys = 4'hA;
    repeat (3) @(negedge clk);
    keys = 4'hE;
    repeat (10) @(negedge clk);
    bus_read(2'd0, 32'h1, "glitch_data");
    bus_read(2'd2, 32'h1, "glitch_ec");
    bus_read(2'd3, {16'd0, model_cnt}, "glitch_cnt");

    // Clear and set on the same edge: set wins
    bus_write(2'd2, 32'hF);
    bus_write(2'd1, 32'hF);
    keys = 4'hA;
    repeat (5) @(negedge clk);
    bus_write(2'd2, 32'h4);
    chk("irq_low_at_set", {63'd0, irq}, 64'd0);
    @(negedge clk);
    chk("irq_set_wins", {63'd0, irq}, 64'd1);
    model_cnt = model_cnt + 16'd1;
    bus_read(2'd2, 32'h4, "set_wins_ec");
    bus_write(2'd2, 32'hF);
    chk("irq_hold_after_clr", {63'd0, irq}, 64'd1);
    @(negedge clk);
    chk("irq_fall", {63'd0, irq}, 64'd0);
    bus_read(2'd2, 32'h0, "ec_cleared");

    // Counter clear, and write plus dual press on the same edge
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, 32'h0, "cnt_clear");
    keys = 4'hF;
    repeat (8) @(negedge clk);
    keys = 4'h6;
    repeat (5) @(negedge clk);
    bus_write(2'd3, 32'h1234);
    bus_read(2'd3, 32'h2, "cnt_write_and_press");
    bus_read(2'd2, 32'h9, "ec_dual_press");

    // Switch latency
    sw = 10'h2A5;
    repeat (SW_LAT - 1) @(negedge clk);
    bus_read(2'd0, 32'h0000_0009, "sw_before");
    bus_read(2'd0, 32'h0000_2A59, "sw_after");

    // Wrap: 4095 rounds of 16 presses plus 15 more reach 0xFFFF
    for (int r = 0; r < 4095; r++) begin
      k2 = 16'h0000;
      repeat (4) @(negedge clk);
      k2 = 16'hFFFF;
      repeat (4) @(negedge clk);
    end
    k2 = 16'h8000;
    repeat (4) @(negedge clk);
    k2 = 16'hFFFF;
    repeat (4) @(negedge clk);
    read2(2'd3, 32'h0000_FFFF, "cnt_ffff");
    k2 = 16'h7FFF;
    repeat (4) @(negedge clk);
    read2(2'd3, 32'h0000_0000, "cnt_wrap");
    k2 = 16'hFFFF;
    repeat (4) @(negedge clk);
    k2 = 16'hFFF6;
    repeat (4) @(negedge clk);
    read2(2'd3, 32'h0000_0002, "cnt_dual_after_wrap");

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
